output_writer: RTL

Receive-side counterpart of the user-stream segmenter. Takes the inbound packetised payload stream (256-byte packets plus one rounded tail packet of 16/32/64/128/256 bytes, zero-padded), strips the padding using the transfer length and emits a contiguous user data stream with first/last/keep framing. It sits between the inbound NWRITE/SWRITE payload path and user logic, and buffers through an internal FIFO for back-pressure.

---
 rtl/output_writer_if.sv | 33 +++
 rtl/output_writer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/output_writer_if.sv
// rtl/output_writer_if.sv - inbound payload beats and outbound user stream of output_writer
// master = payload source / user sink, slave = output_writer.
interface output_writer_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0]   input_tdata;
  logic                    input_tvalid;
  logic                    input_tready;
  logic                    input_pack_tfirst;
  logic                    input_pack_tlast;
  logic [7:0]              input_data_len;

  logic [DATA_WIDTH-1:0]   data_out;
  logic                    data_valid_out;
  logic                    data_first_out;
  logic                    data_last_out;
  logic [DATA_WIDTH/8-1:0] data_keep_out;
  logic                    data_ready_in;

  modport master (
    output input_tdata, input_tvalid, input_pack_tfirst, input_pack_tlast, input_data_len,
    output data_ready_in,
    input  input_tready,
    input  data_out, data_valid_out, data_first_out, data_last_out, data_keep_out
  );

  modport slave (
    input  input_tdata, input_tvalid, input_pack_tfirst, input_pack_tlast, input_data_len,
    input  data_ready_in,
    output input_tready,
    output data_out, data_valid_out, data_first_out, data_last_out, data_keep_out
  );
endinterface

// File: rtl/output_writer.sv
// rtl/output_writer.sv - strips tail padding from inbound packets into a framed user stream
// Accepted real beats go through a FIFO into a registered output stage.
module output_writer #(
  parameter int DATA_WIDTH        = 64,
  parameter int DATA_LENGTH_WIDTH = 20,
  parameter int RAM_ADDR_WIDTH    = 10
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         xfer_start_in,
  input  logic [DATA_LENGTH_WIDTH-1:0] xfer_len_in,
  output_writer_if.slave               bus,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o
);

  localparam int KW    = DATA_WIDTH / 8;
  localparam int BW    = DATA_LENGTH_WIDTH - 3;
  localparam int AW    = RAM_ADDR_WIDTH;
  localparam int FW    = DATA_WIDTH + KW + 2;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   last_beat_q, last_beat_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [KW-1:0]   last_keep_q, last_keep_d;
  logic [4:0]      pkt_beat_q, pkt_beat_d;
  logic [4:0]      pkt_len_q, pkt_len_d;
  logic            in_pkt_q, in_pkt_d;
  logic            err_q, err_d;
  logic            done_q, done_d;

  logic [AW:0]     wr_ptr_q, rd_ptr_q;
  logic [FW-1:0]   mem [0:DEPTH-1];
  logic [FW-1:0]   wr_word;

  logic [DATA_WIDTH-1:0] dout_q;
  logic [KW-1:0]   keep_q;
  logic            first_q, last_q, valid_q;

  logic            full, empty, tready, accept, wr_en, rd_en, is_last;
  logic [4:0]      cur_beat, cur_len;
  logic            unused_len_bits;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign is_last = (beat_cnt_q == last_beat_q);
  assign tready  = (state_q == RECV) ? ~full : (state_q == DISCARD);
  assign accept  = bus.input_tvalid & tready;
  assign wr_en   = accept & (state_q == RECV);
  assign rd_en   = ~empty & (~valid_q | bus.data_ready_in);
  assign wr_word = {bus.input_tdata, (is_last ? last_keep_q : {KW{1'b1}}),
                    (beat_cnt_q == '0), is_last};

  // Packet length is only checked at beat granularity; low bits are unused.
  assign unused_len_bits = ^bus.input_data_len[2:0];

  always_comb begin
    state_d     = state_q;
    last_beat_d = last_beat_q;
    last_keep_d = last_keep_q;
    beat_cnt_d  = beat_cnt_q;
    pkt_beat_d  = pkt_beat_q;
    pkt_len_d   = pkt_len_q;
    in_pkt_d    = in_pkt_q;
    err_d       = err_q;
    done_d      = 1'b0;
    cur_beat    = bus.input_pack_tfirst ? 5'd0 : pkt_beat_q;
    cur_len     = bus.input_pack_tfirst ? bus.input_data_len[7:3] : pkt_len_q;

    case (state_q)
      IDLE: begin
        if (xfer_start_in) begin
          last_beat_d = xfer_len_in[DATA_LENGTH_WIDTH-1:3];
          last_keep_d = {KW{1'b1}} << (3'd7 - xfer_len_in[2:0]);
          beat_cnt_d  = '0;
          pkt_beat_d  = '0;
          in_pkt_d    = 1'b0;
          err_d       = 1'b0;
          state_d     = RECV;
        end
      end
      RECV: begin
        if (wr_en) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (is_last) begin
            done_d  = 1'b1;
            state_d = bus.input_pack_tlast ? IDLE : DISCARD;
          end
        end
      end
      DISCARD: begin
        if (accept && bus.input_pack_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Framing is checked on every accepted beat, padding included.
    if (accept) begin
      if (!in_pkt_q && !bus.input_pack_tfirst) err_d = 1'b1;
      if (bus.input_pack_tlast && (cur_beat != cur_len)) err_d = 1'b1;
      pkt_len_d  = cur_len;
      pkt_beat_d = cur_beat + 5'd1;
      in_pkt_d   = ~bus.input_pack_tlast;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_beat_q <= '0;
      last_keep_q <= '0;
      beat_cnt_q  <= '0;
      pkt_beat_q  <= '0;
      pkt_len_q   <= '0;
      in_pkt_q    <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_beat_q <= last_beat_d;
      last_keep_q <= last_keep_d;
      beat_cnt_q  <= beat_cnt_d;
      pkt_beat_q  <= pkt_beat_d;
      pkt_len_q   <= pkt_len_d;
      in_pkt_q    <= in_pkt_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wr_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
      keep_q   <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (rd_en) begin
        {dout_q, keep_q, first_q, last_q} <= mem[rd_ptr_q[AW-1:0]];
        valid_q  <= 1'b1;
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end else if (bus.data_ready_in) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.input_tready   = tready;
  assign bus.data_out       = dout_q;
  assign bus.data_keep_out  = keep_q;
  assign bus.data_first_out = first_q;
  assign bus.data_last_out  = last_q;
  assign bus.data_valid_out = valid_q;
  assign busy_o             = (state_q != IDLE);
  assign done_o             = done_q;
  assign err_o              = err_q;

endmodule
